// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell, registered borrow.
// Computes D = A - B LSB first over WIDTH cycles with start/done.
module serial_subtractor #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             Z
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] pr_q, pr_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bo_q, bo_d;
    logic             z_q, z_d;

    logic             bit_a;
    logic             bit_b;
    logic             bit_d;
    logic             br_nxt;
    logic [WIDTH-1:0] pr_nxt;
    logic             accept;

    assign bit_a  = sa_q[0];
    assign bit_b  = sb_q[0];
    assign bit_d  = bit_a ^ bit_b ^ br_q;
    assign br_nxt = (~bit_a & bit_b) | (~bit_a & br_q) | (bit_b & br_q);
    assign pr_nxt = {bit_d, pr_q[WIDTH-1:1]};
    // A new request is taken in IDLE or straight out of DONE, never in RUN.
    assign accept = start && (state_q != RUN);

    // Next-state and datapath update for the single time-multiplexed cell.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        pr_d    = pr_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        bo_d    = bo_q;
        z_d     = z_q;
        unique case (state_q)
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                pr_d  = pr_nxt;
                br_d  = br_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    res_d   = pr_nxt;
                    bo_d    = br_nxt;
                    z_d     = (pr_nxt == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (accept) begin
            state_d = RUN;
            sa_d    = A;
            sb_d    = B;
            br_d    = 1'b0;
            cnt_d   = '0;
        end
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            pr_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            bo_q    <= 1'b0;
            z_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            pr_q    <= pr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            bo_q    <= bo_d;
            z_q     <= z_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign D    = res_q;
    assign Bo   = bo_q;
    assign Z    = z_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus queues expected
// results, a negedge monitor pops and compares on each done pulse.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       busy;
    logic       done;
    logic [7:0] D;
    logic       Bo;
    logic       Z;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       z;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] got;
        logic [31:0] exp;
    } chk_t;

    exp_t exp_q[$];
    chk_t chk_q[$];
    int   checks;
    int   errors;
    int   cyc;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bo    (Bo),
        .Z     (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: process posted checks, then score any done pulse.
    initial begin
        checks = 0;
        errors = 0;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                chk_t c;
                c = chk_q.pop_front();
                checks++;
                if (c.got !== c.exp) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h",
                             c.name, c.got, c.exp);
                end
            end
            if (rst_n && done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: D=%0h Bo=%0b", D, Bo);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (D !== e.d || Bo !== e.bo || Z !== e.z) begin
                        errors++;
                        $display("FAIL result: got D=%0h Bo=%0b Z=%0b expected D=%0h Bo=%0b Z=%0b",
                                 D, Bo, Z, e.d, e.bo, e.z);
                    end
                end
            end
        end
    end

    task automatic post(input string n, input logic [31:0] g,
                        input logic [31:0] e);
        chk_t c;
        c.name = n;
        c.got  = g;
        c.exp  = e;
        chk_q.push_back(c);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic bo,
                            input logic z);
        exp_t e;
        e.d  = d;
        e.bo = bo;
        e.z  = z;
        exp_q.push_back(e);
    endtask

    task automatic check_reset(input string tag);
        post({tag, "_busy"}, 32'(busy), 0);
        post({tag, "_done"}, 32'(done), 0);
        post({tag, "_D"},    32'(D), 0);
        post({tag, "_Bo"},   32'(Bo), 0);
        post({tag, "_Z"},    32'(Z), 1);
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ed, input logic eb,
                         input logic ez, input bit glitch);
        int nb;
        bit seen;
        A     = a;
        B     = b;
        start = 1'b1;
        push_exp(ed, eb, ez);
        @(posedge clk); #1;
        start = 1'b0;
        nb    = 0;
        seen  = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (done) begin
                seen = 1;
            end else begin
                if (busy) nb++;
                if (glitch && i == 3) begin
                    start = 1'b1;
                    A     = 8'hFF;
                    B     = 8'h00;
                end else if (glitch && i == 4) begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
            end
        end
        post("busy_cycles", 32'(nb), 8);
        if (!seen) post("done_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_done(output int at);
        bit seen;
        seen = 0;
        at   = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (done) begin
                seen = 1;
                at   = cyc;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!seen) post("done_timeout", 0, 1);
    endtask

    initial begin
        int c1;
        int c2;
        cyc   = 0;
        rst_n = 1'b1;
        start = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
        #3 rst_n = 1'b0;
        #1 check_reset("reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(8'h5A, 8'h21, 8'h39, 1'b0, 1'b0, 0);
        do_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 0);
        do_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 0);
        do_op(8'h77, 8'h77, 8'h00, 1'b0, 1'b1, 1);
        post("idle_D_hold", 32'(D), 32'h00);

        A     = 8'h80;
        B     = 8'h01;
        start = 1'b1;
        push_exp(8'h7F, 1'b0, 1'b0);
        @(posedge clk); #1;
        wait_done(c1);
        A = 8'h03;
        B = 8'h05;
        push_exp(8'hFE, 1'b1, 1'b0);
        @(posedge clk); #1;
        post("run_D_hold", 32'(D), 32'h7F);
        post("rerun_busy", 32'(busy), 1);
        wait_done(c2);
        start = 1'b0;
        post("done_spacing", 32'(c2 - c1), 9);
        @(posedge clk); #1;

        A     = 8'hC3;
        B     = 8'h3C;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        post("abort_in_run", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1 check_reset("abort");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(8'hC3, 8'h3C, 8'h87, 1'b0, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1 post("scoreboard_empty", 32'(exp_q.size()), 0);
        repeat (3) @(negedge clk);
        #1 $display("Simulation finished: %0d checks, %0d errors",
                    checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing D = A - B, LSB first, one bit per clock, using a single 1-bit full-subtractor cell and a registered borrow.
- Complements the full-adder/counter datapath: same bit-cell structure run in the subtract direction, time-multiplexed over one cell instead of a ripple chain.
- Sits beside the register/counter blocks as a low-area arithmetic unit with a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- CW, $clog2(WIDTH+1), bit-counter width (derived, not overridden).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request: latch A/B and begin a subtraction.
- A  input  WIDTH  minuend, sampled only on an accepted start.
- B  input  WIDTH  subtrahend, sampled only on an accepted start.
- busy  output  1  high while a subtraction is in progress (state RUN).
- done  output  1  single-cycle pulse, result valid.
- D  output  WIDTH  difference A - B mod 2^WIDTH, registered.
- Bo  output  1  final borrow (1 when A < B unsigned).
- Z  output  1  D == 0.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, D=0, Bo=0, Z=1; operand shift registers, partial result, borrow, and counter all cleared.
- States: IDLE, RUN, DONE.
- IDLE: start=1 → latch A into sa and B into sb, set borrow=0 and cnt=0, go to RUN. Otherwise stay.
- RUN, each cycle:
  - a=sa[0], b=sb[0].
  - d = a^b^br.
  - br_next = (~a&b) | (~a&br) | (b&br).
  - sa and sb shift right by one.
  - d shifts into the MSB of the partial-result register pr, which shifts right.
  - cnt increments.
  - When cnt == WIDTH-1 (the last bit is processed this cycle), go to DONE.
- DONE, for exactly one cycle:
  - done=1.
  - D, Bo, and Z load from pr, borrow, and (pr==0) at the RUN→DONE edge, so they are valid in the same cycle done is high.
  - Next state is IDLE. If start=1 in DONE, the request is accepted directly, operands are latched, and the next state is RUN.
- busy=1 exactly in RUN. start while in RUN is ignored; operands do not change.
- Latency: start accepted at edge k; done high in the cycle after edge k+WIDTH; total WIDTH+1 cycles from start to done.
- Throughput with start held high: one result every WIDTH+1 cycles.
- D, Bo, and Z hold their values from done until the next completion; they do not change during RUN.
- Arithmetic is unsigned modulo 2^WIDTH; Bo is the borrow out of the MSB.
- Reset asserted mid-RUN aborts the operation: no done pulse, outputs return to reset values.
- A or B changing outside an accepted start has no effect.

Test Plan:
- Reset: drive rst_n low mid-cycle with no clock edge → busy=0, done=0, D=0x00, Bo=0, Z=1 immediately.
- WIDTH=8, A=0x5A, B=0x21, start pulse → busy for 8 cycles, done pulse on cycle 9; D=0x39, Bo=0, Z=0.
- A=0x10, B=0x20 → D=0xF0, Bo=1, Z=0. A=0x00, B=0x01 → D=0xFF, Bo=1, which checks the full borrow ripple.
- A=0x77, B=0x77 → D=0x00, Bo=0, Z=1. Pulse start again during RUN with A=0xFF, B=0x00 → ignored, and the result is still 0x00.
- Hold start=1 continuously. Change A/B after each done to (0x80,0x01), then (0x03,0x05) → D=0x7F/Bo=0, then D=0xFE/Bo=1, with done pulses exactly 9 cycles apart.
- Assert rst_n low at RUN cycle 4 of A=0xC3, B=0x3C → no done pulse, D=0x00, Z=1. A new start after release gives D=0x87, Bo=0.
